// File: rtl/cache_bank_arbiter_pkg.sv
// Shared widths, requester indices, port FSM encoding and the address hazard helper.
// Widths default to 8/8/32 unless NETWORK_ADDRESS_WIDTH, CACHE_BANK_ADDRESS_WIDTH or
// DATA_WIDTH are defined beforehand.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 8
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package cache_bank_arbiter_pkg;

  localparam int unsigned NUM_REQ = 5;
  localparam int unsigned NET_AW  = `NETWORK_ADDRESS_WIDTH;
  localparam int unsigned BANK_AW = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int unsigned DW      = `DATA_WIDTH;

  localparam int unsigned REQ_NORTH = 0;
  localparam int unsigned REQ_SOUTH = 1;
  localparam int unsigned REQ_EAST  = 2;
  localparam int unsigned REQ_WEST  = 3;
  localparam int unsigned REQ_LOCAL = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StResp = 2'd3
  } port_state_e;

  // Two accesses conflict when they hit the same word and at least one of them writes.
  function automatic logic addr_hazard(input logic [BANK_AW-1:0] a_addr, input logic a_wr,
                                       input logic [BANK_AW-1:0] b_addr, input logic b_wr);
    return (a_addr == b_addr) && (a_wr || b_wr);
  endfunction

endpackage

// File: rtl/cache_bank_arbiter_if.sv
// Request, cache-port and response signals of the cache bank arbiter.
// slave: the arbiter side; master: the router/cache/consumer side.
interface cache_bank_arbiter_if;
  import cache_bank_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_write;
  logic [NUM_REQ*BANK_AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0]      req_data;
  logic [NUM_REQ*NET_AW-1:0]  req_requester;
  logic [NUM_REQ-1:0]         req_ready;

  logic [BANK_AW-1:0] cacheAddressIn_A, cacheAddressIn_B;
  logic [DW-1:0]      cacheDataIn_A, cacheDataIn_B;
  logic               memWrite_A, memWrite_B;
  logic [DW-1:0]      cacheDataOut_A, cacheDataOut_B;
  logic               portA_writtenTo, portB_writtenTo;

  logic              resp_valid_A, resp_valid_B;
  logic              resp_ready_A, resp_ready_B;
  logic [DW-1:0]     resp_data_A, resp_data_B;
  logic [NET_AW-1:0] resp_requester_A, resp_requester_B;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_requester,
    input  cacheDataOut_A, cacheDataOut_B, portA_writtenTo, portB_writtenTo,
    input  resp_ready_A, resp_ready_B,
    output req_ready,
    output cacheAddressIn_A, cacheAddressIn_B, cacheDataIn_A, cacheDataIn_B,
    output memWrite_A, memWrite_B,
    output resp_valid_A, resp_valid_B, resp_data_A, resp_data_B,
    output resp_requester_A, resp_requester_B
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, req_requester,
    output cacheDataOut_A, cacheDataOut_B, portA_writtenTo, portB_writtenTo,
    output resp_ready_A, resp_ready_B,
    input  req_ready,
    input  cacheAddressIn_A, cacheAddressIn_B, cacheDataIn_A, cacheDataIn_B,
    input  memWrite_A, memWrite_B,
    input  resp_valid_A, resp_valid_B, resp_data_A, resp_data_B,
    input  resp_requester_A, resp_requester_B
  );

endinterface

// File: rtl/cache_port_sequencer.sv
// One cache port: latches a granted request, walks IDLE -> RD -> RESP or IDLE -> WR,
// drives registered cache-port signals and holds the read response until accepted.
module cache_port_sequencer
  import cache_bank_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               grant_i,
  input  logic               req_write_i,
  input  logic [BANK_AW-1:0] req_addr_i,
  input  logic [DW-1:0]      req_data_i,
  input  logic [NET_AW-1:0]  req_requester_i,
  output logic [BANK_AW-1:0] cache_addr_o,
  output logic [DW-1:0]      cache_data_o,
  output logic               mem_write_o,
  input  logic [DW-1:0]      cache_rdata_i,
  input  logic               written_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [DW-1:0]      resp_data_o,
  output logic [NET_AW-1:0]  resp_requester_o,
  output logic               idle_o,
  output logic               busy_o,
  output logic [BANK_AW-1:0] busy_addr_o,
  output logic               busy_write_o
);

  port_state_e        state_q, state_d;
  logic               write_q, write_d;
  logic [BANK_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [NET_AW-1:0]  requester_q, requester_d;
  logic [BANK_AW-1:0] cache_addr_q, cache_addr_d;
  logic [DW-1:0]      cache_data_q, cache_data_d;
  logic               mem_write_q, mem_write_d;
  logic [DW-1:0]      resp_data_q, resp_data_d;

  // Next state, request latch and registered cache-port values derived from the next state.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    requester_d = requester_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          write_d     = req_write_i;
          addr_d      = req_addr_i;
          data_d      = req_data_i;
          requester_d = req_requester_i;
          state_d     = req_write_i ? StWr : StRd;
        end
      end
      StRd: begin
        resp_data_d = cache_rdata_i;
        state_d     = StResp;
      end
      StResp: if (resp_ready_i) state_d = StIdle;
      StWr:   if (written_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    cache_addr_d = '0;
    cache_data_d = '0;
    mem_write_d  = 1'b0;
    if (state_d == StRd || state_d == StWr) begin
      cache_addr_d = addr_d;
    end
    if (state_d == StWr) begin
      cache_data_d = data_d;
      mem_write_d  = 1'b1;
    end
  end

  // State and datapath registers; reset clears everything, aborting any write in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      requester_q  <= '0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
      mem_write_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      requester_q  <= requester_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
      mem_write_q  <= mem_write_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign cache_addr_o     = cache_addr_q;
  assign cache_data_o     = cache_data_q;
  assign mem_write_o      = mem_write_q;
  assign resp_valid_o     = (state_q == StResp);
  assign resp_data_o      = resp_data_q;
  assign resp_requester_o = requester_q;
  assign idle_o           = (state_q == StIdle);
  assign busy_o           = (state_q == StRd) || (state_q == StWr);
  assign busy_addr_o      = addr_q;
  assign busy_write_o     = write_q;

endmodule

// File: rtl/cache_bank_arbiter.sv
// Round-robin, hazard-aware arbiter granting up to two of five requesters per cycle onto
// the two ports of a cache bank. Optional CACHE_ARB_PERF_EN adds saturating grant and
// hazard-conflict counters.
module cache_bank_arbiter
  import cache_bank_arbiter_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  cache_bank_arbiter_if.slave bus
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grants,
  output logic [31:0]         perf_conflicts
`endif
);

  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic               grant_a, grant_b, conflict;
  logic [2:0]         idx_a, idx_b;
  logic [NUM_REQ-1:0] ready;
  logic               a_idle, b_idle, a_busy, b_busy, a_busy_write, b_busy_write;
  logic [BANK_AW-1:0] a_busy_addr, b_busy_addr;

  // Scan from rr_ptr; first eligible request takes the first idle port, the second takes B.
  always_comb begin
    int s;
    int nxt;
    logic [BANK_AW-1:0] cand_addr, first_addr;
    logic cand_wr, first_wr;
    s          = 0;
    nxt        = 0;
    cand_addr  = '0;
    cand_wr    = 1'b0;
    first_addr = '0;
    first_wr   = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    idx_a      = '0;
    idx_b      = '0;
    conflict   = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
      nxt = (s + 1 == int'(NUM_REQ)) ? 0 : s + 1;
      cand_addr = bus.req_addr[s*int'(BANK_AW) +: BANK_AW];
      cand_wr   = bus.req_write[s];
      if (bus.req_valid[s] && !reset) begin
        if (!grant_a && !grant_b) begin
          if (a_idle) begin
            if (b_busy && addr_hazard(cand_addr, cand_wr, b_busy_addr, b_busy_write)) begin
              conflict = 1'b1;
            end else begin
              grant_a    = 1'b1;
              idx_a      = 3'(s);
              first_addr = cand_addr;
              first_wr   = cand_wr;
              rr_ptr_d   = 3'(nxt);
            end
          end else if (b_idle) begin
            if (a_busy && addr_hazard(cand_addr, cand_wr, a_busy_addr, a_busy_write)) begin
              conflict = 1'b1;
            end else begin
              grant_b  = 1'b1;
              idx_b    = 3'(s);
              rr_ptr_d = 3'(nxt);
            end
          end
        end else if (grant_a && !grant_b && b_idle) begin
          // Port A is idle here, so the only hazard left is the request just granted to A.
          if (addr_hazard(cand_addr, cand_wr, first_addr, first_wr)) begin
            conflict = 1'b1;
          end else begin
            grant_b  = 1'b1;
            idx_b    = 3'(s);
            rr_ptr_d = 3'(nxt);
          end
        end
      end
    end
  end

  // One-hot/two-hot grant vector back to the requesters.
  always_comb begin
    ready = '0;
    if (grant_a) ready[idx_a] = 1'b1;
    if (grant_b) ready[idx_b] = 1'b1;
  end

  assign bus.req_ready = ready;

  // Round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  cache_port_sequencer u_port_a (
    .clk              (clk),
    .reset            (reset),
    .grant_i          (grant_a),
    .req_write_i      (bus.req_write[idx_a]),
    .req_addr_i       (bus.req_addr[idx_a*BANK_AW +: BANK_AW]),
    .req_data_i       (bus.req_data[idx_a*DW +: DW]),
    .req_requester_i  (bus.req_requester[idx_a*NET_AW +: NET_AW]),
    .cache_addr_o     (bus.cacheAddressIn_A),
    .cache_data_o     (bus.cacheDataIn_A),
    .mem_write_o      (bus.memWrite_A),
    .cache_rdata_i    (bus.cacheDataOut_A),
    .written_i        (bus.portA_writtenTo),
    .resp_valid_o     (bus.resp_valid_A),
    .resp_ready_i     (bus.resp_ready_A),
    .resp_data_o      (bus.resp_data_A),
    .resp_requester_o (bus.resp_requester_A),
    .idle_o           (a_idle),
    .busy_o           (a_busy),
    .busy_addr_o      (a_busy_addr),
    .busy_write_o     (a_busy_write)
  );

  cache_port_sequencer u_port_b (
    .clk              (clk),
    .reset            (reset),
    .grant_i          (grant_b),
    .req_write_i      (bus.req_write[idx_b]),
    .req_addr_i       (bus.req_addr[idx_b*BANK_AW +: BANK_AW]),
    .req_data_i       (bus.req_data[idx_b*DW +: DW]),
    .req_requester_i  (bus.req_requester[idx_b*NET_AW +: NET_AW]),
    .cache_addr_o     (bus.cacheAddressIn_B),
    .cache_data_o     (bus.cacheDataIn_B),
    .mem_write_o      (bus.memWrite_B),
    .cache_rdata_i    (bus.cacheDataOut_B),
    .written_i        (bus.portB_writtenTo),
    .resp_valid_o     (bus.resp_valid_B),
    .resp_ready_i     (bus.resp_ready_B),
    .resp_data_o      (bus.resp_data_B),
    .resp_requester_o (bus.resp_requester_B),
    .idle_o           (b_idle),
    .busy_o           (b_busy),
    .busy_addr_o      (b_busy_addr),
    .busy_write_o     (b_busy_write)
  );

`ifdef CACHE_ARB_PERF_EN
  logic [31:0] grants_q, grants_d, conflicts_q, conflicts_d;
  logic [32:0] grants_sum;

  // Saturating counters.
  always_comb begin
    grants_sum  = {1'b0, grants_q} + 33'(grant_a) + 33'(grant_b);
    grants_d    = grants_sum[32] ? '1 : grants_sum[31:0];
    conflicts_d = (conflict && conflicts_q != '1) ? conflicts_q + 32'd1 : conflicts_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q    <= '0;
      conflicts_q <= '0;
    end else begin
      grants_q    <= grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign perf_grants    = grants_q;
  assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Directed bench for cache_bank_arbiter with a combinational-read cache model.
module tb_cache_bank_arbiter;
  import cache_bank_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [DW-1:0] mem [0:(1<<BANK_AW)-1];

  cache_bank_arbiter_if bus ();

`ifdef CACHE_ARB_PERF_EN
  logic [31:0] perf_grants, perf_conflicts;
`endif

  cache_bank_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef CACHE_ARB_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  assign bus.cacheDataOut_A = mem[bus.cacheAddressIn_A];
  assign bus.cacheDataOut_B = mem[bus.cacheAddressIn_B];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [BANK_AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]                   = v;
    bus.req_write[i]                   = w;
    bus.req_addr[i*BANK_AW +: BANK_AW] = a;
    bus.req_data[i*DW +: DW]           = d;
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b1;
    bus.req_valid       = '0;
    bus.req_write       = '0;
    bus.req_addr        = '0;
    bus.req_data        = '0;
    bus.req_requester   = '0;
    bus.portA_writtenTo = 1'b0;
    bus.portB_writtenTo = 1'b0;
    bus.resp_ready_A    = 1'b0;
    bus.resp_ready_B    = 1'b0;
    for (int i = 0; i < (1 << BANK_AW); i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h11110000;
    mem[8'h20] = 32'h0BAD0000;
    for (int i = 0; i < 5; i++) mem[8'h40 + i] = 32'hC0DE0000 + i;
    mem[8'h60] = 32'h60606060;
    mem[8'h63] = 32'h63636363;
    for (int i = 0; i < int'(NUM_REQ); i++) bus.req_requester[i*NET_AW +: NET_AW] = 8'(8'hA0 + i);

    // Reset state
    tick();
    tick();
    check("rst_ready", bus.req_ready, 0);
    check("rst_memwr_a", bus.memWrite_A, 0);
    check("rst_addr_a", bus.cacheAddressIn_A, 0);
    check("rst_respv_a", bus.resp_valid_A, 0);
    check("rst_respv_b", bus.resp_valid_B, 0);
    reset = 1'b0;

    // Single read from Local
    set_req(REQ_LOCAL, 1, 0, 8'h10, 0);
    #1 check("t1_ready", bus.req_ready, 5'b10000);
    tick();
    set_req(REQ_LOCAL, 0, 0, 8'h10, 0);
    check("t1_addr_a", bus.cacheAddressIn_A, 8'h10);
    check("t1_memwr_a", bus.memWrite_A, 0);
    check("t1_respv_early", bus.resp_valid_A, 0);
    tick();
    check("t1_respv", bus.resp_valid_A, 1);
    check("t1_data", bus.resp_data_A, 32'hDEADBEEF);
    check("t1_reqr", bus.resp_requester_A, 8'hA4);
    bus.resp_ready_A = 1'b1;
    tick();
    check("t1_resp_done", bus.resp_valid_A, 0);

    // All five reads pending, responses taken immediately
    bus.resp_ready_B = 1'b1;
    for (int i = 0; i < 5; i++) set_req(i, 1, 0, 8'(8'h40 + i), 0);
    #1 check("t3_grant01", bus.req_ready, 5'b00011);
    tick();
    check("t3_busy_ready", bus.req_ready, 0);
    check("t3_addr_a0", bus.cacheAddressIn_A, 8'h40);
    check("t3_addr_b0", bus.cacheAddressIn_B, 8'h41);
    tick();
    check("t3_respv_a", bus.resp_valid_A, 1);
    check("t3_data_a0", bus.resp_data_A, 32'hC0DE0000);
    check("t3_reqr_a0", bus.resp_requester_A, 8'hA0);
    check("t3_data_b0", bus.resp_data_B, 32'hC0DE0001);
    check("t3_reqr_b0", bus.resp_requester_B, 8'hA1);
    check("t3_resp_ready", bus.req_ready, 0);
    tick();
    check("t3_grant23", bus.req_ready, 5'b01100);
    tick();
    tick();
    check("t3_data_a1", bus.resp_data_A, 32'hC0DE0002);
    check("t3_data_b1", bus.resp_data_B, 32'hC0DE0003);
    tick();
    check("t3_grant40", bus.req_ready, 5'b10001);
    tick();
    tick();
    check("t3_data_a2", bus.resp_data_A, 32'hC0DE0004);
    check("t3_data_b2", bus.resp_data_B, 32'hC0DE0000);
    check("t3_reqr_b2", bus.resp_requester_B, 8'hA0);
    bus.req_valid = '0;
    tick();
    check("t3_idle_ready", bus.req_ready, 0);
    // Pointer now 1: requester 2 is scanned before 0
    set_req(REQ_NORTH, 1, 0, 8'h40, 0);
    set_req(REQ_EAST, 1, 0, 8'h42, 0);
    #1 check("t3_wrap_ready", bus.req_ready, 5'b00101);
    tick();
    bus.req_valid = '0;
    check("t3_wrap_a", bus.cacheAddressIn_A, 8'h42);
    check("t3_wrap_b", bus.cacheAddressIn_B, 8'h40);
    tick();
    tick();

    // Write North with a delayed acknowledge
    set_req(REQ_NORTH, 1, 1, 8'h05, 32'h1234);
    #1 check("t2_ready", bus.req_ready, 5'b00001);
    tick();
    bus.req_valid = '0;
    check("t2_memwr_c1", bus.memWrite_A, 1);
    check("t2_addr", bus.cacheAddressIn_A, 8'h05);
    check("t2_wdata", bus.cacheDataIn_A, 32'h1234);
    tick();
    check("t2_memwr_c2", bus.memWrite_A, 1);
    tick();
    check("t2_memwr_c3", bus.memWrite_A, 1);
    bus.portA_writtenTo = 1'b1;
    tick();
    bus.portA_writtenTo = 1'b0;
    check("t2_memwr_off", bus.memWrite_A, 0);
    check("t2_no_resp", bus.resp_valid_A, 0);
    check("t2_addr_off", bus.cacheAddressIn_A, 0);
    set_req(REQ_LOCAL, 1, 0, 8'h11, 0);
    #1 check("t2_regrant", bus.req_ready, 5'b10000);
    tick();
    bus.req_valid = '0;
    tick();
    check("t2_read_data", bus.resp_data_A, 32'h11110000);
    tick();

    // Write/read hazard on the same address
    set_req(REQ_NORTH, 1, 1, 8'h20, 32'h5555);
    set_req(REQ_SOUTH, 1, 0, 8'h20, 0);
    #1 check("t4_only_n", bus.req_ready, 5'b00001);
    tick();
    set_req(REQ_NORTH, 0, 1, 8'h20, 32'h5555);
    #1 check("t4_s_blocked1", bus.req_ready, 0);
    tick();
    check("t4_s_blocked2", bus.req_ready, 0);
    bus.portA_writtenTo = 1'b1;
    mem[8'h20] = 32'h5555;
    tick();
    bus.portA_writtenTo = 1'b0;
    check("t4_s_grant", bus.req_ready, 5'b00010);
    tick();
    bus.req_valid = '0;
    check("t4_s_addr", bus.cacheAddressIn_A, 8'h20);
    check("t4_s_memwr", bus.memWrite_A, 0);
    tick();
    check("t4_s_data", bus.resp_data_A, 32'h5555);
    check("t4_s_reqr", bus.resp_requester_A, 8'hA1);
    tick();

    // Response back-pressure on port B
    bus.resp_ready_B = 1'b0;
    set_req(REQ_EAST, 1, 0, 8'h42, 0);
    set_req(REQ_WEST, 1, 0, 8'h43, 0);
    #1 check("t5_grant23", bus.req_ready, 5'b01100);
    tick();
    bus.req_valid = '0;
    tick();
    check("t5_b_data1", bus.resp_data_B, 32'hC0DE0003);
    tick();
    set_req(REQ_LOCAL, 1, 0, 8'h44, 0);
    set_req(REQ_NORTH, 1, 0, 8'h40, 0);
    #1 check("t5_a_only", bus.req_ready, 5'b10000);
    check("t5_b_data2", bus.resp_data_B, 32'hC0DE0003);
    tick();
    set_req(REQ_LOCAL, 0, 0, 8'h44, 0);
    #1 check("t5_none3", bus.req_ready, 0);
    check("t5_b_valid3", bus.resp_valid_B, 1);
    check("t5_b_data3", bus.resp_data_B, 32'hC0DE0003);
    tick();
    check("t5_none4", bus.req_ready, 0);
    check("t5_b_data4", bus.resp_data_B, 32'hC0DE0003);
    check("t5_a_data", bus.resp_data_A, 32'hC0DE0004);
    bus.resp_ready_B = 1'b1;
    tick();
    check("t5_b_done", bus.resp_valid_B, 0);
    check("t5_after_hs", bus.req_ready, 5'b00001);
    bus.req_valid = '0;

    // Reset in the middle of a write
    set_req(REQ_SOUTH, 1, 1, 8'h30, 32'hAA);
    #1 check("t6_ready_w", bus.req_ready, 5'b00010);
    tick();
    bus.req_valid = '0;
    check("t6_memwr", bus.memWrite_A, 1);
    set_req(REQ_EAST, 1, 0, 8'h50, 0);
    #1 check("t6_ready_b", bus.req_ready, 5'b00100);
    reset = 1'b1;
    #1;
    check("t6_memwr_rst", bus.memWrite_A, 0);
    check("t6_ready_rst", bus.req_ready, 0);
    check("t6_respv_a", bus.resp_valid_A, 0);
    check("t6_respv_b", bus.resp_valid_B, 0);
    check("t6_addr_rst", bus.cacheAddressIn_A, 0);
    check("t6_data_rst", bus.resp_data_A, 0);
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
    set_req(REQ_NORTH, 1, 0, 8'h60, 0);
    set_req(REQ_WEST, 1, 0, 8'h63, 0);
    #1 check("t6_ptr_ready", bus.req_ready, 5'b01001);
    tick();
    bus.req_valid = '0;
    check("t6_ptr_a", bus.cacheAddressIn_A, 8'h60);
    check("t6_ptr_b", bus.cacheAddressIn_B, 8'h63);
    tick();
    check("t6_data_a", bus.resp_data_A, 32'h60606060);
    check("t6_data_b", bus.resp_data_B, 32'h63636363);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
- Sits between the router's five request sources (North, South, East, West, Local) and the dual-port local cache bank inside a network node.
- Each cycle it grants up to two pending read/write requests, round-robin, one onto each cache port (A, B).
- It sequences each port through issue, write-acknowledge and response phases.
- It returns read data, tagged with the requester address, on a per-port valid/ready response channel.

Parameters:
NUM_REQ, 5, number of requesters, fixed; index 0=N, 1=S, 2=E, 3=W, 4=Local
NET_AW, `NETWORK_ADDRESS_WIDTH, width of the requester network address
BANK_AW, `CACHE_BANK_ADDRESS_WIDTH, width of the cache bank word address
DW, `DATA_WIDTH, width of a data word

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*BANK_AW  flattened bank addresses; slice i = requester i
req_data  in  NUM_REQ*DW  flattened write data
req_requester  in  NUM_REQ*NET_AW  flattened requester network addresses
req_ready  out  NUM_REQ  grant; a transfer occurs when req_valid[i] & req_ready[i]
cacheAddressIn_A / cacheAddressIn_B  out  BANK_AW  cache port address
cacheDataIn_A / cacheDataIn_B  out  DW  cache port write data
memWrite_A / memWrite_B  out  1  cache port write enable
cacheDataOut_A / cacheDataOut_B  in  DW  cache read data, one cycle after the address
portA_writtenTo / portB_writtenTo  in  1  cache write-complete acknowledge
resp_valid_A / resp_valid_B  out  1  read response valid
resp_ready_A / resp_ready_B  in  1  response consumer ready
resp_data_A / resp_data_B  out  DW  read data
resp_requester_A / resp_requester_B  out  NET_AW  requester address of the response

Behaviour:
- Reset (async, high): all outputs 0; port FSMs go to IDLE; rr_ptr=0; all captured request registers cleared.
- Per-port FSM: IDLE, RD, WR, RESP.
  - IDLE: on grant, latch addr/data/requester/write; go to RD or WR next edge.
  - RD: drive cacheAddressIn with the latched address, memWrite=0; next edge go to RESP, capturing cacheDataOut into resp_data.
  - RESP: resp_valid=1, data and requester held stable; go to IDLE on resp_valid&resp_ready.
  - WR: drive address and data with memWrite=1, held until portX_writtenTo=1; go to IDLE on that edge. Writes produce no response.
- Read latency: grant edge t, address driven during t+1, resp_valid asserted from edge t+2.
- Cache outputs are registered from FSM state, so they are glitch-free. When the port is not in RD/WR, address, data and memWrite are 0.
- Arbitration (combinational, registered pointer):
  - Scan order starts at rr_ptr and wraps modulo 5.
  - First eligible valid goes to port A if A is IDLE, otherwise to port B if B is IDLE.
  - Second eligible valid goes to the remaining IDLE port.
  - req_ready is one-hot or two-hot, and never asserted for a port that is not IDLE.
- Pointer update: rr_ptr <= (index of the last grant this cycle + 1) mod 5; unchanged if there is no grant.
- Hazard rule: a candidate is ineligible if its address equals the address of either of the following, and either side is a write:
  - the other candidate granted in the same cycle;
  - a request in flight (RD/WR) on the other port.
  - An ineligible request is skipped this cycle, not dropped; it stays pending.
- Simultaneous events:
  - A port exiting RESP or WR is not IDLE during that cycle, so it cannot be granted the same cycle. Single-port throughput is therefore one read per 3 cycles minimum.
  - Same-address reads on both ports are allowed.
- Requesters must hold req_* stable while req_valid=1 and not granted.
- Reset mid-operation aborts any pending write: memWrite drops immediately. No response is generated.

Optional Feature:
- Macro: CACHE_ARB_PERF_EN.
- Defined: adds outputs perf_grants (32-bit, count of granted transfers) and perf_conflicts (32-bit, count of cycles in which at least one valid request was skipped by the hazard rule). Both saturate at all-ones and clear on reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include globalVariables.v holds the width macros, the requester index constants (REQ_NORTH..REQ_LOCAL) and the port-FSM state encodings.
- One sub-module, cache_port_sequencer, is instantiated twice (A, B). It owns the FSM, the latched request and the response register. The top module holds the round-robin and hazard logic.

Test Plan:
- Single read from Local, addr 0x10, cache returns 0xDEADBEEF: cacheAddressIn_A=0x10 at t+1; resp_valid_A=1 with resp_data_A=0xDEADBEEF and resp_requester_A = Local's address at t+2.
- Write N addr 0x05 data 0x1234, writtenTo delayed 3 cycles: memWrite_A held 3 cycles; no response; port A is IDLE and grantable after the ack edge.
- All 5 valid reads to distinct addresses, with responses taken immediately: grant order {0,1}, {2,3}, {4,0}; rr_ptr wraps correctly.
- N write 0x20 and S read 0x20 pending together: only N is granted. S is granted after N's WR completes, and reads the new data.
- resp_ready_B held low 4 cycles: resp_data_B remains stable and port B receives no grant until the handshake.
- Reset asserted during WR on port A: memWrite_A, resp_valid_* and req_ready all drop to 0 asynchronously; rr_ptr returns to 0.
